// File: rtl/ks_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready flow control and LEVELS+2 cycle latency.
// Define KS_ADDER_PIPE_SAT_EN to clamp signed-overflowing results to the signed max/min.
module ks_adder_pipe #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   localparam int LEVELS = $clog2(WIDTH);

   logic             advance;
   logic [WIDTH-1:0] be;
   logic [WIDTH-1:0] gv;
   logic [WIDTH-1:0] pv;
   logic             cin_eff;

   // Tree index 0 holds the carry-in; index i holds bit i-1, so entry i ends up as the carry into bit i.
   logic [WIDTH-1:0] tg [0:LEVELS];
   logic [WIDTH-1:0] tp [0:LEVELS];
   logic [WIDTH-1:0] ng [1:LEVELS];
   logic [WIDTH-1:0] np [1:LEVELS];
   logic [WIDTH-1:0] bp [0:LEVELS];
   logic [LEVELS:0]  am;
   logic [LEVELS:0]  bm;
   logic [LEVELS:0]  vld;

   logic [WIDTH-1:0] sum_raw;
   logic [WIDTH-1:0] sum_next;
   logic             cout_next;
   logic             ovf_next;
   logic             unused_p;

   assign in_ready = out_ready || !out_valid;
   assign advance  = in_ready;
   assign be       = sub ? ~b : b;
   assign cin_eff  = sub ? 1'b1 : cin;
   assign gv       = a & be;
   assign pv       = a ^ be;
   assign unused_p = ^tp[LEVELS];

   for (genvar k = 1; k <= LEVELS; k++) begin : g_level
      localparam int S = 1 << (k - 1);
      for (genvar j = 0; j < WIDTH; j++) begin : g_bit
         if (j < S) begin : g_pass
            assign ng[k][j] = tg[k-1][j];
            assign np[k][j] = tp[k-1][j];
         end else if (j < 2 * S) begin : g_gray
            // Group now reaches the carry-in, so its propagate is known to be zero.
            assign ng[k][j] = tg[k-1][j] | (tp[k-1][j] & tg[k-1][j-S]);
            assign np[k][j] = 1'b0;
         end else begin : g_black
            assign ng[k][j] = tg[k-1][j] | (tp[k-1][j] & tg[k-1][j-S]);
            assign np[k][j] = tp[k-1][j] & tp[k-1][j-S];
         end
      end
   end

   always_comb begin
      sum_raw   = bp[LEVELS] ^ tg[LEVELS];
      cout_next = (am[LEVELS] & bm[LEVELS]) |
                  ((am[LEVELS] ^ bm[LEVELS]) & tg[LEVELS][WIDTH-1]);
      ovf_next  = (am[LEVELS] == bm[LEVELS]) && (sum_raw[WIDTH-1] != am[LEVELS]);
      sum_next  = sum_raw;
`ifdef KS_ADDER_PIPE_SAT_EN
      if (ovf_next) begin
         sum_next = am[LEVELS] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end
`endif
   end

   // A single global enable: a stalled output freezes every stage, data and valid alike.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld <= '0;
         am  <= '0;
         bm  <= '0;
         for (int k = 0; k <= LEVELS; k++) begin
            tg[k] <= '0;
            tp[k] <= '0;
            bp[k] <= '0;
         end
         out_valid <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
         ovf       <= 1'b0;
      end else if (advance) begin
         vld[0] <= in_valid;
         tg[0]  <= {gv[WIDTH-2:0], cin_eff};
         tp[0]  <= {pv[WIDTH-2:0], 1'b0};
         bp[0]  <= pv;
         am[0]  <= a[WIDTH-1];
         bm[0]  <= be[WIDTH-1];
         for (int k = 1; k <= LEVELS; k++) begin
            vld[k] <= vld[k-1];
            tg[k]  <= ng[k];
            tp[k]  <= np[k];
            bp[k]  <= bp[k-1];
            am[k]  <= am[k-1];
            bm[k]  <= bm[k-1];
         end
         out_valid <= vld[LEVELS];
         sum       <= sum_next;
         cout      <= cout_next;
         ovf       <= ovf_next;
      end
   end
endmodule
